// File: rtl/serial_adder_param.sv
// serial_adder_param: digit-serial adder/subtractor.
// Adds two WIDTH-bit operands DIGIT bits per clock, LSB digit first, under a
// start/busy/done handshake. Subtraction is done by inverting B and folding
// the borrow into the initial carry when the operation is launched.
// Optional build macro SERIAL_ADDER_ACC_EN adds an 'acc' input that takes
// operand A from the current s output (running accumulation).

module serial_adder_param #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef SERIAL_ADDER_ACC_EN
    input  logic             acc,
`endif
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    // Reject configurations the digit slicing cannot handle.
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_adder_param: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;        // operand A, shifted right one digit per RUN cycle
    logic [WIDTH-1:0] r_b;        // transformed operand B, shifted alongside r_a
    logic [WIDTH-1:0] r_sum;      // result digits enter at the top and move down
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ovf;

    logic [WIDTH-1:0] w_a_src;
    logic [DIGIT:0]   w_dsum;
    logic             w_cmsb;
    logic [WIDTH-1:0] w_sum_next;

`ifdef SERIAL_ADDER_ACC_EN
    assign w_a_src = acc ? r_s : a;
`else
    assign w_a_src = a;
`endif

    // One digit of addition: the low digit of each shifted operand plus carry.
    assign w_dsum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                  + {{DIGIT{1'b0}}, r_carry};

    // Carry into the top bit of this digit, recovered from the sum bit.
    // On the last digit this is the carry into bit WIDTH-1.
    assign w_cmsb = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_dsum[DIGIT-1];

    // After N shifts the first digit computed sits at the bottom of r_sum.
    assign w_sum_next = (r_sum >> DIGIT)
                      | (WIDTH'(w_dsum[DIGIT-1:0]) << (WIDTH - DIGIT));

    // Control FSM and datapath; outputs are registered and only move on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_a     <= w_a_src;
                        r_b     <= b ^ {WIDTH{sub}};
                        r_carry <= cin ^ sub;
                        r_sum   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_sum   <= w_sum_next;
                    r_carry <= w_dsum[DIGIT];
                    if (r_cnt == LAST_CNT) begin
                        r_s     <= w_sum_next;
                        r_cout  <= w_dsum[DIGIT];
                        r_ovf   <= w_cmsb ^ w_dsum[DIGIT];
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= DONE;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign s    = r_s;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder_param.sv
// Bench for serial_adder_param: three configurations (32/8, 16/16, 12/4)
// share one set of stimulus; results are compared with an arithmetic model.

module tb_serial_adder_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sub_in = 1'b0;
    logic        cin_in = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
`ifdef SERIAL_ADDER_ACC_EN
    logic        acc_in = 1'b0;
`endif

    logic [31:0] s32;
    logic [15:0] s16;
    logic [11:0] s12;
    logic busy32, done32, cout32, ovf32;
    logic busy16, done16, cout16, ovf16;
    logic busy12, done12, cout12, ovf12;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_adder_param #(.WIDTH(32), .DIGIT(8)) dut32 (
        .clk(clk), .rst_n(rst_n),
`ifdef SERIAL_ADDER_ACC_EN
        .acc(acc_in),
`endif
        .start(start), .sub(sub_in), .a(a_in), .b(b_in), .cin(cin_in),
        .busy(busy32), .done(done32), .s(s32), .cout(cout32), .ovf(ovf32)
    );

    serial_adder_param #(.WIDTH(16), .DIGIT(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
`ifdef SERIAL_ADDER_ACC_EN
        .acc(acc_in),
`endif
        .start(start), .sub(sub_in), .a(a_in[15:0]), .b(b_in[15:0]), .cin(cin_in),
        .busy(busy16), .done(done16), .s(s16), .cout(cout16), .ovf(ovf16)
    );

    serial_adder_param #(.WIDTH(12), .DIGIT(4)) dut12 (
        .clk(clk), .rst_n(rst_n),
`ifdef SERIAL_ADDER_ACC_EN
        .acc(acc_in),
`endif
        .start(start), .sub(sub_in), .a(a_in[11:0]), .b(b_in[11:0]), .cin(cin_in),
        .busy(busy12), .done(done12), .s(s12), .cout(cout12), .ovf(ovf12)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: w-bit add/subtract with plain integer arithmetic.
    // Returns {ovf, cout, sum[63:0]}.
    function automatic logic [65:0] ref_add(input int w, input logic [31:0] ra,
                                            input logic [31:0] rb, input logic rsub,
                                            input logic rcin);
        logic [63:0] mask, av, bv, full, sres;
        logic        co, ov;
        mask = (64'd1 << w) - 64'd1;
        av   = {32'd0, ra} & mask;
        bv   = rsub ? (~{32'd0, rb} & mask) : ({32'd0, rb} & mask);
        full = av + bv + {63'd0, rcin ^ rsub};
        sres = full & mask;
        co   = full[w];
        ov   = (av[w-1] == bv[w-1]) && (sres[w-1] != av[w-1]);
        return {ov, co, sres};
    endfunction

    // Launch one operation on all three instances and check latency, busy
    // duration, single done pulse and results.
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb,
                         input logic tsub, input logic tcin);
        int lat32 = -1, lat16 = -1, lat12 = -1;
        int d32 = 0, d16 = 0, d12 = 0, b32 = 0;
        logic [65:0] e32, e16, e12;
        @(negedge clk);
        a_in = ta; b_in = tb; sub_in = tsub; cin_in = tcin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) @(negedge clk);
            if (busy32) b32++;
            if (done32) begin d32++; if (lat32 < 0) lat32 = c; end
            if (done16) begin d16++; if (lat16 < 0) lat16 = c; end
            if (done12) begin d12++; if (lat12 < 0) lat12 = c; end
        end
        e32 = ref_add(32, ta, tb, tsub, tcin);
        e16 = ref_add(16, ta, tb, tsub, tcin);
        e12 = ref_add(12, ta, tb, tsub, tcin);
        chk("lat32", 64'(lat32), 64'd4);
        chk("lat16", 64'(lat16), 64'd1);
        chk("lat12", 64'(lat12), 64'd3);
        chk("ndone32", 64'(d32), 64'd1);
        chk("ndone16", 64'(d16), 64'd1);
        chk("ndone12", 64'(d12), 64'd1);
        chk("busy32_cycles", 64'(b32), 64'd4);
        chk("s32", {32'd0, s32}, e32[63:0]);
        chk("s16", {48'd0, s16}, e16[63:0]);
        chk("s12", {52'd0, s12}, e12[63:0]);
        chk("flags32", {62'd0, ovf32, cout32}, {62'd0, e32[65:64]});
        chk("flags16", {62'd0, ovf16, cout16}, {62'd0, e16[65:64]});
        chk("flags12", {62'd0, ovf12, cout12}, {62'd0, e12[65:64]});
    endtask

    initial begin
        int ndone;
        logic [31:0] ra, rb;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_out32", {29'd0, busy32, done32, cout32 | ovf32, s32}, 64'd0);
            chk("rst_out16", {45'd0, busy16, done16, cout16 | ovf16, s16}, 64'd0);
            chk("rst_out12", {49'd0, busy12, done12, cout12 | ovf12, s12}, 64'd0);
        end
        rst_n = 1'b1;

        // Directed operations from the plan, with explicit expected values
        do_op(32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b0);
        chk("plan_add_s", {32'd0, s32}, 64'hFFFFFFFF);
        chk("plan_add_f", {62'd0, ovf32, cout32}, 64'd0);
        do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
        chk("plan_ovf_s", {32'd0, s32}, 64'h80000000);
        chk("plan_ovf_f", {62'd0, ovf32, cout32}, 64'd2);
        do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1);
        chk("plan_cin_s", {32'd0, s32}, 64'h00000001);
        chk("plan_cin_f", {62'd0, ovf32, cout32}, 64'd1);
        do_op(32'd5, 32'd7, 1'b1, 1'b0);
        chk("plan_sub_s", {32'd0, s32}, 64'hFFFFFFFE);
        chk("plan_sub_f", {62'd0, ovf32, cout32}, 64'd0);
        do_op(32'h80000000, 32'd1, 1'b1, 1'b0);
        chk("plan_subovf_s", {32'd0, s32}, 64'h7FFFFFFF);
        chk("plan_subovf_f", {62'd0, ovf32, cout32}, 64'd3);
        do_op(32'd5, 32'd7, 1'b1, 1'b1);
        chk("plan_subb_s", {32'd0, s32}, 64'hFFFFFFFD);

        // Start during RUN ignored; operand changes after start ignored
        @(negedge clk);
        a_in = 32'h100; b_in = 32'h23; sub_in = 1'b0; cin_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a_in = 32'hDEAD0000; b_in = 32'h0000BEEF;
        @(negedge clk);
        start = 1'b1; a_in = 32'hFFFFFFFF; b_in = 32'h1; sub_in = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("hs_run_busy", {63'd0, busy32}, 64'd1);
        chk("hs_run_nodone", {63'd0, done32}, 64'd0);
        @(negedge clk);
        chk("hs_done", {63'd0, done32}, 64'd1);
        chk("hs_s", {32'd0, s32}, 64'h123);
        @(negedge clk);
        chk("hs_pulse_end", {62'd0, done32, busy32}, 64'd0);
        chk("hs_s_hold", {32'd0, s32}, 64'h123);
        repeat (4) @(negedge clk);

        // Back-to-back start accepted in the DONE cycle
        @(negedge clk);
        a_in = 32'd1000; b_in = 32'd234; sub_in = 1'b0; cin_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        chk("b2b_done1", {63'd0, done32}, 64'd1);
        chk("b2b_s1", {32'd0, s32}, 64'd1234);
        start = 1'b1; a_in = 32'd7; b_in = 32'd8;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", {63'd0, busy32}, 64'd1);
        chk("b2b_s_stable", {32'd0, s32}, 64'd1234);
        repeat (3) @(negedge clk);
        chk("b2b_not_yet", {63'd0, done32}, 64'd0);
        @(negedge clk);
        chk("b2b_done2", {63'd0, done32}, 64'd1);
        chk("b2b_s2", {32'd0, s32}, 64'd15);
        repeat (3) @(negedge clk);

        // Asynchronous reset at RUN cnt=2 aborts the operation
        @(negedge clk);
        a_in = 32'h1234; b_in = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_busy", {63'd0, busy32}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_s", {32'd0, s32}, 64'd0);
        chk("mid_rst_ctl", {60'd0, busy32, done32, cout32, ovf32}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done32) ndone++;
        end
        chk("mid_no_done", 64'(ndone), 64'd0);
        do_op(32'd1, 32'd1, 1'b0, 1'b0);
        chk("post_rst_s", {32'd0, s32}, 64'd2);

        // Randomized sweep across all three configurations
        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 8 == 0) ra = 32'hFFFFFFFF;
            if (i % 8 == 1) ra = 32'h80000000;
            if (i % 16 == 2) rb = 32'h7FFFFFFF;
            do_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
